// File: rtl/trace_step_ctrl.sv
// trace_step_ctrl: run/step/breakpoint controller for a single-issue core.
// The core is gated through oCpuEn. Every cycle in which oCpuEn is high
// retires one instruction, and that {PC, instruction} pair is pushed into a
// circular trace buffer that can be read back combinationally, oldest first.
// oState exposes the FSM encoding for debug (0 HALT, 1 RUN, 2 STEP, 3 BREAK).
module trace_step_ctrl #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 16,
    parameter int NUM_BP = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 iMode,
    input  logic                       iStep,
    input  logic [NUM_BP-1:0]          iBpEn,
    input  logic [NUM_BP*XLEN-1:0]     iBpAddr,
    input  logic [XLEN-1:0]            iPC,
    input  logic [31:0]                iInstruction,
    input  logic [$clog2(DEPTH)-1:0]   iTraceIdx,
    output logic                       oCpuEn,
    output logic                       oHalted,
    output logic [NUM_BP-1:0]          oBpHit,
    output logic [XLEN-1:0]            oTracePC,
    output logic [31:0]                oTraceInstr,
    output logic [$clog2(DEPTH):0]     oTraceCount,
    output logic                       oTraceOvf,
    output logic [XLEN-1:0]            oCycleCount,
    output logic [1:0]                 oState
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL_COUNT = (IW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    state_t state;
    state_t stateNext;

    // Mode decode; the unused encoding 11 behaves exactly like HALT.
    logic modeRun;
    logic modeStep;
    logic modeHalt;

    assign modeRun  = (iMode == 2'b01);
    assign modeStep = (iMode == 2'b10);
    assign modeHalt = !modeRun && !modeStep;

    // Step button edge detector.
    logic stepPrev;
    logic stepEdge;

    assign stepEdge = iStep && !stepPrev;

    // Skip flag lets the breakpointed instruction retire once after resuming.
    logic skip;
    logic setSkip;

    // Breakpoint comparators.
    logic [NUM_BP-1:0] bpEqual;
    logic [NUM_BP-1:0] bpMatchVec;
    logic              bpMatch;

    // Trace storage and bookkeeping.
    logic [XLEN-1:0] pcMem    [DEPTH];
    logic [31:0]     instrMem [DEPTH];
    logic [IW-1:0]   wrPtr;
    logic [IW-1:0]   oldestPtr;
    logic [IW-1:0]   rdAddr;
    logic            rdInRange;

    // Compare every enabled breakpoint PC against the current PC.
    always_comb begin
        bpEqual = '0;
        for (int k = 0; k < NUM_BP; k++) begin
            bpEqual[k] = iBpEn[k] && (iBpAddr[k*XLEN +: XLEN] == iPC);
        end
    end

    // A match only counts while running and not skipping the resumed instruction.
    assign bpMatchVec = (state == S_RUN && !skip) ? bpEqual : '0;
    assign bpMatch    = |bpMatchVec;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_HALT;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next-state logic; a mode change out of RUN wins over a breakpoint.
    always_comb begin
        stateNext = state;
        setSkip   = 1'b0;
        case (state)
            S_HALT: begin
                if (modeRun) begin
                    stateNext = S_RUN;
                end else if (modeStep && stepEdge) begin
                    stateNext = S_STEP;
                end
            end
            S_RUN: begin
                if (!modeRun) begin
                    stateNext = S_HALT;
                end else if (bpMatch) begin
                    stateNext = S_BREAK;
                end
            end
            S_STEP: begin
                stateNext = S_HALT;
            end
            S_BREAK: begin
                if (modeHalt) begin
                    stateNext = S_HALT;
                end else if (stepEdge && modeRun) begin
                    stateNext = S_RUN;
                    setSkip   = 1'b1;
                end else if (stepEdge && modeStep) begin
                    stateNext = S_STEP;
                end
            end
            default: begin
                stateNext = S_HALT;
            end
        endcase
    end

    // FSM outputs; a breakpoint hit gates the core in the same cycle.
    always_comb begin
        oCpuEn  = 1'b0;
        oHalted = 1'b0;
        case (state)
            S_HALT:  oHalted = 1'b1;
            S_RUN:   oCpuEn  = !bpMatch;
            S_STEP:  oCpuEn  = 1'b1;
            S_BREAK: oHalted = 1'b1;
            default: oHalted = 1'b1;
        endcase
    end

    assign oState = state;

    // Sample the step button once per cycle for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stepPrev <= 1'b0;
        end else begin
            stepPrev <= iStep;
        end
    end

    // Skip flag: armed on resume from BREAK, cleared by the first retired instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skip <= 1'b0;
        end else if (setSkip) begin
            skip <= 1'b1;
        end else if (oCpuEn) begin
            skip <= 1'b0;
        end
    end

    // Sticky breakpoint hit flags, one per comparator.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oBpHit <= '0;
        end else begin
            oBpHit <= oBpHit | bpMatchVec;
        end
    end

    // Retired-cycle counter, wraps naturally at 2^XLEN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oCycleCount <= '0;
        end else if (oCpuEn) begin
            oCycleCount <= oCycleCount + 1'b1;
        end
    end

    // Trace write pointer, fill count and overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr       <= '0;
            oTraceCount <= '0;
            oTraceOvf   <= 1'b0;
        end else if (oCpuEn) begin
            wrPtr <= wrPtr + 1'b1;
            if (oTraceCount != FULL_COUNT) begin
                oTraceCount <= oTraceCount + 1'b1;
            end else begin
                oTraceOvf <= 1'b1;
            end
        end
    end

    // Trace storage; contents survive reset, only the count is cleared.
    always_ff @(posedge clock) begin
        if (oCpuEn) begin
            pcMem[wrPtr]    <= iPC;
            instrMem[wrPtr] <= iInstruction;
        end
    end

    // Until the buffer wraps the oldest entry is slot 0; afterwards it is
    // the slot the next write will overwrite.
    assign oldestPtr = (oTraceCount == FULL_COUNT) ? wrPtr : '0;
    assign rdAddr    = oldestPtr + iTraceIdx;
    assign rdInRange = ({1'b0, iTraceIdx} < oTraceCount);

    // Combinational trace read, zero for indices past the valid entries.
    always_comb begin
        oTracePC    = '0;
        oTraceInstr = '0;
        if (rdInRange) begin
            oTracePC    = pcMem[rdAddr];
            oTraceInstr = instrMem[rdAddr];
        end
    end

endmodule

// File: tb/tb_trace_step_ctrl.sv
// Directed bench for trace_step_ctrl: run/trace, breakpoint and resume,
// single stepping, trace wrap-around and asynchronous reset mid-run.
module tb_trace_step_ctrl;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int NUM_BP = 2;
    localparam int IW     = 4;

    localparam logic [1:0] M_HALT = 2'b00;
    localparam logic [1:0] M_RUN  = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;

    logic                   clock;
    logic                   reset;
    logic [1:0]             iMode;
    logic                   iStep;
    logic [NUM_BP-1:0]      iBpEn;
    logic [NUM_BP*XLEN-1:0] iBpAddr;
    logic [XLEN-1:0]        iPC;
    logic [31:0]            iInstruction;
    logic [IW-1:0]          iTraceIdx;
    logic                   oCpuEn;
    logic                   oHalted;
    logic [NUM_BP-1:0]      oBpHit;
    logic [XLEN-1:0]        oTracePC;
    logic [31:0]            oTraceInstr;
    logic [IW:0]            oTraceCount;
    logic                   oTraceOvf;
    logic [XLEN-1:0]        oCycleCount;
    logic [1:0]             oState;

    int checks = 0;
    int errors = 0;

    logic [31:0] expQ[$];

    trace_step_ctrl #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .NUM_BP (NUM_BP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iMode        (iMode),
        .iStep        (iStep),
        .iBpEn        (iBpEn),
        .iBpAddr      (iBpAddr),
        .iPC          (iPC),
        .iInstruction (iInstruction),
        .iTraceIdx    (iTraceIdx),
        .oCpuEn       (oCpuEn),
        .oHalted      (oHalted),
        .oBpHit       (oBpHit),
        .oTracePC     (oTracePC),
        .oTraceInstr  (oTraceInstr),
        .oTraceCount  (oTraceCount),
        .oTraceOvf    (oTraceOvf),
        .oCycleCount  (oCycleCount),
        .oState       (oState)
    );

    // Clock and reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset pulse placed between clock edges.
    task automatic applyReset();
        iStep = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    // Read one trace entry; the DUT must be idle so the spent cycle changes nothing.
    task automatic readTrace(input int idx, output logic [31:0] pc, output logic [31:0] instr);
        iTraceIdx = IW'(idx);
        tick();
        pc    = oTracePC;
        instr = oTraceInstr;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] expPc;

        reset        = 1'b1;
        iMode        = M_HALT;
        iStep        = 1'b0;
        iBpEn        = '0;
        iBpAddr      = '0;
        iPC          = '0;
        iInstruction = '0;
        iTraceIdx    = '0;

        // Reset state, sampled while reset is still held
        #12;
        check("rst_cpuen", oCpuEn, 0);
        check("rst_halted", oHalted, 1);
        check("rst_state", oState, 0);
        check("rst_tracecount", oTraceCount, 0);
        check("rst_cyclecount", oCycleCount, 0);
        check("rst_bphit", oBpHit, 0);
        check("rst_ovf", oTraceOvf, 0);
        reset = 1'b0;
        tick();

        // Plain RUN for five instructions, leaving on the last one
        iMode = M_RUN;
        #1;
        check("s1_halt_cpuen", oCpuEn, 0);
        tick();
        for (int n = 0; n < 5; n++) begin
            iPC          = 32'(4 * n);
            iInstruction = 32'h1300_0000 + 32'(n);
            iMode        = (n == 4) ? M_HALT : M_RUN;
            #1;
            check("s1_run_cpuen", oCpuEn, 1);
            tick();
        end
        check("s1_state", oState, 0);
        check("s1_cyclecount", oCycleCount, 5);
        check("s1_tracecount", oTraceCount, 5);
        check("s1_ovf", oTraceOvf, 0);
        readTrace(0, pc, instr);
        check("s1_idx0_pc", pc, 32'h00);
        check("s1_idx0_instr", instr, 32'h1300_0000);
        readTrace(4, pc, instr);
        check("s1_idx4_pc", pc, 32'h10);
        readTrace(5, pc, instr);
        check("s1_idx5_pc_zero", pc, 0);
        check("s1_idx5_instr_zero", instr, 0);

        // Breakpoint on comparator 0 at 0x0C
        applyReset();
        iBpEn   = 2'b01;
        iBpAddr = {32'h0000_0100, 32'h0000_000C};
        iMode   = M_RUN;
        tick();
        for (int n = 0; n < 3; n++) begin
            iPC          = 32'(4 * n);
            iInstruction = 32'h2300_0000 + 32'(n);
            #1;
            check("s2_run_cpuen", oCpuEn, 1);
            tick();
        end
        iPC          = 32'h0C;
        iInstruction = 32'h2300_0003;
        #1;
        check("s2_bp_gate", oCpuEn, 0);
        tick();
        check("s2_state_break", oState, 3);
        check("s2_halted", oHalted, 1);
        check("s2_cpuen_break", oCpuEn, 0);
        check("s2_bphit", oBpHit, 2'b01);
        check("s2_tracecount", oTraceCount, 3);
        check("s2_cyclecount", oCycleCount, 3);
        readTrace(2, pc, instr);
        check("s2_idx2_pc", pc, 32'h08);
        readTrace(3, pc, instr);
        check("s2_idx3_not_traced", pc, 0);

        // Resume from BREAK with a step edge in RUN mode
        iStep = 1'b1;
        #1;
        check("s3_break_cpuen", oCpuEn, 0);
        tick();
        check("s3_state_run", oState, 1);
        check("s3_skip_retire", oCpuEn, 1);
        tick();
        iStep = 1'b0;
        check("s3_tracecount", oTraceCount, 4);
        check("s3_state_still_run", oState, 1);
        iPC = 32'h10;
        iInstruction = 32'h2300_0004;
        #1;
        check("s3_run_0x10", oCpuEn, 1);
        tick();
        iPC = 32'h0C;
        #1;
        check("s3_rehit_gate", oCpuEn, 0);
        tick();
        check("s3_state_rebreak", oState, 3);
        check("s3_tracecount_after", oTraceCount, 5);
        check("s3_bphit", oBpHit, 2'b01);
        readTrace(3, pc, instr);
        check("s3_idx3_pc", pc, 32'h0C);
        readTrace(4, pc, instr);
        check("s3_idx4_pc", pc, 32'h10);
        iMode = M_HALT;
        tick();
        check("s3_state_halt", oState, 0);
        check("s3_bphit_sticky", oBpHit, 2'b01);

        // Single stepping: three spaced presses, then one long hold
        applyReset();
        iBpEn = '0;
        iMode = M_STEP;
        tick();
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < 4; c++) begin
                iStep = (c < 2);
                #1;
                check("s4_step_pulse", oCpuEn, (c == 1));
                tick();
            end
        end
        check("s4_cyclecount", oCycleCount, 3);
        check("s4_tracecount", oTraceCount, 3);
        for (int c = 0; c < 6; c++) begin
            iStep = 1'b1;
            #1;
            check("s4_hold_pulse", oCpuEn, (c == 1));
            tick();
        end
        iStep = 1'b0;
        check("s4_cyclecount_hold", oCycleCount, 4);

        // Trace wrap-around: 20 retirements into a 16-entry buffer, leave via mode 11
        applyReset();
        iMode = M_RUN;
        tick();
        for (int n = 0; n < 20; n++) begin
            iPC          = 32'(4 * n);
            iInstruction = 32'hA000_0000 + 32'(n);
            iMode        = (n == 19) ? 2'b11 : M_RUN;
            if (n == 16) begin
                check("s5_full_count", oTraceCount, 16);
                check("s5_full_no_ovf", oTraceOvf, 0);
            end
            if (n >= 4) expQ.push_back(32'(4 * n));
            #1;
            tick();
        end
        check("s5_state_halt_mode11", oState, 0);
        check("s5_tracecount", oTraceCount, 16);
        check("s5_ovf", oTraceOvf, 1);
        check("s5_cyclecount", oCycleCount, 20);
        for (int i = 0; i < DEPTH; i++) begin
            readTrace(i, pc, instr);
            expPc = expQ.pop_front();
            check("s5_trace_pc", pc, expPc);
            check("s5_trace_instr", instr, 32'hA000_0000 + (expPc >> 2));
        end
        readTrace(0, pc, instr);
        check("s5_idx0_pc", pc, 32'h10);
        readTrace(15, pc, instr);
        check("s5_idx15_pc", pc, 32'h4C);

        // Asynchronous reset in the middle of a RUN cycle
        iMode = M_RUN;
        tick();
        iPC = 32'h80;
        #1;
        check("s6_run_cpuen", oCpuEn, 1);
        tick();
        check("s6_cyclecount_pre", oCycleCount, 21);
        reset = 1'b1;
        #2;
        check("s6_cpuen", oCpuEn, 0);
        check("s6_halted", oHalted, 1);
        check("s6_state", oState, 0);
        check("s6_tracecount", oTraceCount, 0);
        check("s6_ovf", oTraceOvf, 0);
        check("s6_cyclecount", oCycleCount, 0);
        reset = 1'b0;
        iMode = M_HALT;
        tick();
        check("s6_state_after", oState, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_step_ctrl.md
TRACE_STEP_CTRL -- requirements
Module: trace_step_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width of the core being controlled.
REQ-002 SHALL have parameter DEPTH, default 16, meaning trace buffer entries; a power of 2, at least 2.
REQ-003 SHALL have parameter NUM_BP, default 2, meaning number of PC breakpoint comparators; at least 1.
REQ-004 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port iMode  input  2  00 HALT, 01 RUN, 10 STEP, 11 treated as HALT.
REQ-007 SHALL have port iStep  input  1  level from a button; only its rising edge acts, detected against the previous-cycle sample.
REQ-008 SHALL have port iBpEn  input  NUM_BP  per-comparator enable.
REQ-009 SHALL have port iBpAddr  input  NUM_BP*XLEN  breakpoint PCs; comparator k uses bits [k*XLEN +: XLEN].
REQ-010 SHALL have port iPC  input  XLEN  current PC of the core.
REQ-011 SHALL have port iInstruction  input  32  instruction at iPC.
REQ-012 SHALL have port iTraceIdx  input  log2(DEPTH)  trace read index; 0 is the oldest valid entry.
REQ-013 SHALL have port oCpuEn  output  1  clock enable to the core; the core retires one instruction per cycle while it is high.
REQ-014 SHALL have port oHalted  output  1  high in HALT and BREAK.
REQ-015 SHALL have port oBpHit  output  NUM_BP  sticky per-comparator hit flags.
REQ-016 SHALL have port oTracePC  output  XLEN  PC of the selected trace entry.
REQ-017 SHALL have port oTraceInstr  output  32  instruction of the selected trace entry.
REQ-018 SHALL have port oTraceCount  output  log2(DEPTH)+1  number of valid entries, saturating at DEPTH.
REQ-019 SHALL have port oTraceOvf  output  1  sticky; set when an entry overwrites an older one.
REQ-020 SHALL have port oCycleCount  output  XLEN  count of oCpuEn-high cycles; wraps modulo 2^XLEN.

Function
REQ-021 SHALL implement an FSM with states HALT, RUN, STEP and BREAK.
REQ-022 In HALT: iMode=RUN SHALL go to RUN; iMode=STEP with an iStep edge SHALL go to STEP; otherwise the FSM SHALL stay in HALT.
REQ-023 In RUN: iMode other than RUN SHALL go to HALT, with priority over breakpoints.
REQ-024 In RUN: an enabled comparator with iBpAddr equal to iPC, and the skip flag clear, SHALL go to BREAK.
REQ-025 In RUN: on a breakpoint match with the skip flag clear, oCpuEn SHALL be 0 combinationally in that same cycle, so the breakpointed instruction does not retire.
REQ-026 In RUN: on a breakpoint match, every matching comparator SHALL set its oBpHit bit.
REQ-027 STEP SHALL drive oCpuEn=1 for exactly one cycle, then go to HALT; breakpoints SHALL be ignored in STEP.
REQ-028 In BREAK: iMode=HALT SHALL go to HALT.
REQ-029 In BREAK: an iStep edge with iMode=RUN SHALL go to RUN and set the skip flag.
REQ-030 In BREAK: an iStep edge with iMode=STEP SHALL go to STEP.
REQ-031 The skip flag SHALL suppress breakpoint matching until the first oCpuEn-high cycle, then clear.
REQ-032 oCpuEn SHALL be 1 in RUN except when REQ-025 applies, 1 in STEP, and 0 in HALT and BREAK.
REQ-033 Each oCpuEn-high cycle SHALL write {iPC, iInstruction} at the write pointer and advance the pointer modulo DEPTH.
REQ-034 oTraceCount SHALL increment on each trace write until it reaches DEPTH.
REQ-035 A trace write with oTraceCount=DEPTH SHALL overwrite the oldest entry and set oTraceOvf.
REQ-036 Trace read SHALL be combinational: entry (oldest + iTraceIdx) mod DEPTH.
REQ-037 Trace read with iTraceIdx >= oTraceCount SHALL return zeros.
REQ-038 oBpHit and oTraceOvf SHALL clear only on reset.

Reset
REQ-039 Reset asserted SHALL, asynchronously, set state=HALT, oCpuEn=0, oHalted=1, skip flag=0, oBpHit=0, oTraceCount=0, oTraceOvf=0, oCycleCount=0, write pointer=0 and the iStep edge sampler=0.
REQ-040 Reset SHALL take effect immediately even mid-RUN or mid-STEP; trace storage contents need not clear.

Verification
REQ-041 Scenario: reset, iMode=RUN for 5 cycles with iPC=0x00,0x04,...,0x10 -> oCpuEn=1, oCycleCount=5, oTraceCount=5, oTracePC at iTraceIdx=0 is 0x00.
REQ-042 Scenario: iBpEn=01, iBpAddr[0]=0x0C, RUN -> at iPC=0x0C oCpuEn=0 in that cycle, then BREAK, oHalted=1, oBpHit=01, and 0x0C is not traced.
REQ-043 Scenario: from the REQ-042 end state, iStep edge with iMode=RUN -> 0x0C retires once, the FSM stays in RUN, and a re-hit occurs only on a later return to 0x0C.
REQ-044 Scenario: iMode=STEP with 3 iStep edges spaced 4 cycles -> exactly 3 oCpuEn pulses of 1 cycle each, and iStep held high produces no extra step.
REQ-045 Scenario: DEPTH=16, RUN for 20 cycles with iPC=4*n -> oTraceCount=16, oTraceOvf=1, iTraceIdx=0 gives 0x10, iTraceIdx=15 gives 0x4C.
REQ-046 Scenario: reset pulse mid-RUN between clock edges -> oCpuEn=0 and oTraceCount=0 before the next clock edge.
